// File: rtl/config_chain_loader.sv
// Word-to-serial loader for the PE configuration scan chain.
// Shifts host words LSB first and collects the bits leaving the chain as read-back words.
module config_chain_loader #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              config_clk,
    output logic              config_reset,
    output logic              config_in,
    input  logic              config_out,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE, CRST, FETCH, SHL, SHH, FIN
    } state_e;

    state_e            state_q, state_d;
    logic              crst_q, crst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WORD_W-1:0] rbuf_q, rbuf_d;

    logic              in_ready_q, in_ready_d;
    logic              config_clk_q, config_clk_d;
    logic              config_reset_q, config_reset_d;
    logic              config_in_q, config_in_d;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              word_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            crst_q         <= 1'b0;
            rem_q          <= '0;
            idx_q          <= '0;
            sreg_q         <= '0;
            rbuf_q         <= '0;
            in_ready_q     <= 1'b0;
            config_clk_q   <= 1'b0;
            config_reset_q <= 1'b0;
            config_in_q    <= 1'b0;
            rb_valid_q     <= 1'b0;
            rb_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            crst_q         <= crst_d;
            rem_q          <= rem_d;
            idx_q          <= idx_d;
            sreg_q         <= sreg_d;
            rbuf_q         <= rbuf_d;
            in_ready_q     <= in_ready_d;
            config_clk_q   <= config_clk_d;
            config_reset_q <= config_reset_d;
            config_in_q    <= config_in_d;
            rb_valid_q     <= rb_valid_d;
            rb_data_q      <= rb_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crst_d  = crst_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        rbuf_d  = rbuf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = chain_len;
                    crst_d  = 1'b0;
                    state_d = CRST;
                end
            end
            CRST: begin
                if (crst_q) begin
                    state_d = (rem_q == '0) ? FIN : FETCH;
                end else begin
                    crst_d = 1'b1;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    idx_d   = '0;
                    rbuf_d  = '0;
                    state_d = SHL;
                end
            end
            SHL: begin
                rbuf_d[idx_q] = config_out;
                state_d       = SHH;
            end
            SHH: begin
                rem_d = rem_q - LEN_ONE;
                idx_d = idx_q + IDX_W'(1);
                if (rem_q == LEN_ONE) begin
                    state_d = FIN;
                end else if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = SHL;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        in_ready_d     = (state_d == FETCH);
        config_clk_d   = (state_d == SHH);
        config_reset_d = (state_d == CRST);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == FIN);
        word_end       = (state_q == SHH) &&
                         ((rem_q == LEN_ONE) || (idx_q == IDX_LAST));
        rb_valid_d     = word_end;
        rb_data_d      = word_end ? rbuf_q : rb_data_q;
        config_in_d    = 1'b0;
        if (state_d == SHL) begin
            config_in_d = sreg_d[idx_d];
        end else if (state_d == SHH) begin
            config_in_d = config_in_q;
        end
    end

    assign in_ready     = in_ready_q;
    assign config_clk   = config_clk_q;
    assign config_reset = config_reset_q;
    assign config_in    = config_in_q;
    assign rb_valid     = rb_valid_q;
    assign rb_data      = rb_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Serial configuration loader that drives the PE configuration scan chain (config_clk / config_reset / config_in) from a word-wide host stream, and captures the bits leaving the chain's config_out as read-back words. It is the driving end of the chain formed by the config cells and switch blocks inside each BlockPE tile, and sits between the host/config-memory interface and the first tile of the fabric. The whole block runs on the single system clock.

## Interface
Parameters:
- WORD_W, 32, width of host and read-back words
- LEN_W, 16, width of the chain-length operand

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- chain_len  in  LEN_W  total chain length in bits; sampled when start is accepted
- in_valid  in  1  host word available
- in_ready  out  1  loader accepts a host word this cycle
- in_data  in  WORD_W  host configuration word
- config_clk  out  1  registered chain shift clock
- config_reset  out  1  registered chain reset
- config_in  out  1  serial bit into the chain
- config_out  in  1  serial bit leaving the chain's last cell
- rb_valid  out  1  one-cycle strobe: rb_data holds a read-back word
- rb_data  out  WORD_W  read-back word; no backpressure
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle strobe at load completion

## Operation
- States: IDLE, CRST, FETCH, SHL (shift low phase), SHH (shift high phase), FIN.
- IDLE: busy=0. start=1 latches chain_len into a remaining-bit counter and moves to CRST. start is ignored in every other state.
- CRST: config_reset=1 for exactly 2 cycles, then FETCH. If the latched length is 0, go directly to FIN.
- FETCH: in_ready=1. On in_valid&&in_ready, load in_data into the shift register, set bit index to 0, go to SHL.
- SHL: config_clk=0; config_in = shift-register bit [index]. Sample config_out into read-back bit [index] at the end of this cycle. Then SHH.
- SHH: config_clk=1, with config_in held. Decrement the remaining count and increment the index. Next state:
  - remaining==0: FIN.
  - index wrapped to WORD_W: FETCH.
  - otherwise: SHL.
- Bit order: words are consumed in arrival order, LSB first. The final word uses only its low (chain_len mod WORD_W) bits, or all bits if the remainder is 0. Upper bits are discarded, and no extra word is fetched.
- Read-back: rb_valid pulses for 1 cycle after the SHH that completes a word, or after the last SHH (partial word, upper bits zero). It carries the bits that exited the chain, first exiting bit in bit 0.
- FIN: done=1 for one cycle, then IDLE.
- in_valid while not in FETCH is ignored; the word is not consumed.

## Timing
- Reset values: in_ready=0, config_clk=0, config_reset=0, config_in=0, rb_valid=0, rb_data=0, busy=0, done=0. State is IDLE, counters 0.
- Reset asserted mid-load aborts immediately, with outputs at reset values and no done strobe. The chain contents are undefined; the host must restart.
- All outputs are registered and derived from state; no combinational path from input to output.
- start accepted at edge t:
  - busy=1 and config_reset=1 in cycles t+1 and t+2.
  - in_ready=1 from t+3.
- Each bit takes 2 cycles: one low phase, then one high phase, so the config_clk rising edge is at the SHL→SHH edge. config_in is stable for the full low and high phases.
- Word boundary: one FETCH cycle minimum between the last SHH of a word and the next SHL. It is longer while in_valid=0, and config_clk stays 0 throughout.
- Total cycles with ideal host: 2 + ceil(L/WORD_W)*1 + 2L, then FIN. busy falls the cycle after done.

## Test plan
- chain_len=5, word 0x15 → config_in across the 5 low phases = 1,0,1,0,1; exactly 5 config_clk pulses; 1 word consumed; done 14 cycles after start.
- chain_len=40, words 0xA5A5A5A5 then 0x000000FF → 40 pulses, the last 8 bits all 1; only 2 words consumed; the next host word is left unconsumed.
- Backpressure: chain_len=64, in_valid low for 10 cycles at the second FETCH → config_clk stays 0, in_ready stays 1, no bits lost; the sequence matches the no-stall run.
- Read-back: model the chain as a 40-bit shift register preloaded with 0x12_3456789A; load any data → rb_data=0x3456789A, then 0x00000012, with rb_valid pulses at the word boundaries.
- Reset asserted during the SHH of bit 17 → all outputs return to 0 in the same cycle, no done; a fresh start then completes normally.
- start while busy is ignored (length unchanged); chain_len=0 → 2 config_reset cycles, 0 pulses, no in_ready, then done.
